// File: rtl/online_mult_pkg.sv
// Shared definitions for the online multiplier datapath: sequencer FSM encoding
// and the default digit-address width.
package online_mult_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int ADDR_W_DEFAULT = 9;

endpackage : online_mult_pkg

// File: rtl/addr_seq_counter_if.sv
// Command/status bundle of the address sequencer.
// Optional macro ADDR_SEQ_DOWN_EN adds the count-direction signal `down`.
interface addr_seq_counter_if
  import online_mult_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEFAULT
) ();

  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             ready;
  logic             wrap;
  logic             done;
`ifdef ADDR_SEQ_DOWN_EN
  logic             down;

  modport master (output enable, clear, load, load_val, down,
                  input  cnt, ready, wrap, done);
  modport slave  (input  enable, clear, load, load_val, down,
                  output cnt, ready, wrap, done);
`else
  modport master (output enable, clear, load, load_val,
                  input  cnt, ready, wrap, done);
  modport slave  (input  enable, clear, load, load_val,
                  output cnt, ready, wrap, done);
`endif

endinterface : addr_seq_counter_if

// File: rtl/addr_seq_counter.sv
// Digit-address sequencer with one warm-up cycle after reset, wrap or saturate at LAST.
// Optional macro ADDR_SEQ_DOWN_EN enables decrementing via bus.down.
module addr_seq_counter
  import online_mult_pkg::*;
#(
  parameter int          WIDTH     = ADDR_W_DEFAULT,
  parameter int unsigned LAST      = (1 << WIDTH) - 1,
  parameter bit          WRAP_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  addr_seq_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] LastV = WIDTH'(LAST);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             stepDown;
  logic             atLimit;
  logic [WIDTH-1:0] loadClamped;

`ifdef ADDR_SEQ_DOWN_EN
  assign stepDown = bus.down;
`else
  assign stepDown = 1'b0;
`endif

  // The limit is 0 when decrementing and LAST when incrementing.
  assign atLimit     = stepDown ? (cnt_q == '0) : (cnt_q == LastV);
  assign loadClamped = (bus.load_val > LastV) ? LastV : bus.load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.clear && !bus.load && bus.enable && atLimit && !WRAP_MODE)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.clear || bus.load)
          state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Next register values; done and ready follow directly from the next state.
  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d != ST_INIT);
    unique case (state_q)
      ST_INIT: cnt_d = '0;
      ST_RUN: begin
        if (bus.clear) begin
          cnt_d = '0;
        end else if (bus.load) begin
          cnt_d = loadClamped;
        end else if (bus.enable) begin
          if (!atLimit) begin
            cnt_d = stepDown ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
          end else if (WRAP_MODE) begin
            cnt_d  = stepDown ? LastV : '0;
            wrap_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.clear) begin
          cnt_d = '0;
        end else if (bus.load) begin
          cnt_d = loadClamped;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.cnt   = cnt_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;
  assign bus.ready = ready_q;

endmodule : addr_seq_counter

// File: tb/tb_addr_seq_counter.sv
// Randomised bench for addr_seq_counter: four parameterisations driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_addr_seq_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, clear, load, down;
  logic [9:0] lvRaw;

  int vectorCount = 0;
  int miscompareCount = 0;

  int mCnt[4];
  int mReady[4];
  int mWrap[4];
  int mDone[4];
  int mWarm[4];
  int mLast[4]     = '{511, 5, 5, 511};
  int mWrapMode[4] = '{1, 1, 0, 0};
  int mWidth[4]    = '{9, 4, 4, 10};

  always #5 clk = ~clk;

  addr_seq_counter_if #(.WIDTH(9))  busA ();
  addr_seq_counter_if #(.WIDTH(4))  busB ();
  addr_seq_counter_if #(.WIDTH(4))  busC ();
  addr_seq_counter_if #(.WIDTH(10)) busD ();

  assign busA.enable = enable;  assign busA.clear = clear;  assign busA.load = load;
  assign busB.enable = enable;  assign busB.clear = clear;  assign busB.load = load;
  assign busC.enable = enable;  assign busC.clear = clear;  assign busC.load = load;
  assign busD.enable = enable;  assign busD.clear = clear;  assign busD.load = load;
  assign busA.load_val = lvRaw[8:0];
  assign busB.load_val = lvRaw[3:0];
  assign busC.load_val = lvRaw[3:0];
  assign busD.load_val = lvRaw;
`ifdef ADDR_SEQ_DOWN_EN
  assign busA.down = down;
  assign busB.down = down;
  assign busC.down = down;
  assign busD.down = down;
`endif

  addr_seq_counter #(.WIDTH(9), .LAST(511), .WRAP_MODE(1'b1))
    dutA (.clk(clk), .rst(rst), .bus(busA));
  addr_seq_counter #(.WIDTH(4), .LAST(5), .WRAP_MODE(1'b1))
    dutB (.clk(clk), .rst(rst), .bus(busB));
  addr_seq_counter #(.WIDTH(4), .LAST(5), .WRAP_MODE(1'b0))
    dutC (.clk(clk), .rst(rst), .bus(busC));
  addr_seq_counter #(.WIDTH(10), .LAST(511), .WRAP_MODE(1'b0))
    dutD (.clk(clk), .rst(rst), .bus(busD));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      mCnt[i] = 0; mReady[i] = 0; mWrap[i] = 0; mDone[i] = 0; mWarm[i] = 0;
    end
  endfunction

  function automatic void modelStep();
    for (int i = 0; i < 4; i++) begin
      int lv;
      int nxt;
      lv = int'(lvRaw) % (1 << mWidth[i]);
      mWrap[i] = 0;
      if (mWarm[i] == 0) begin
        mWarm[i] = 1; mReady[i] = 1; mCnt[i] = 0;
      end else if (clear) begin
        mCnt[i] = 0; mDone[i] = 0;
      end else if (load) begin
        mCnt[i] = (lv > mLast[i]) ? mLast[i] : lv; mDone[i] = 0;
      end else if (enable && mDone[i] == 0) begin
        nxt = mCnt[i] + (down ? -1 : 1);
        if (nxt < 0 || nxt > mLast[i]) begin
          if (mWrapMode[i] != 0) begin
            mCnt[i] = (nxt < 0) ? mLast[i] : 0;
            mWrap[i] = 1;
          end else begin
            mDone[i] = 1;
          end
        end else begin
          mCnt[i] = nxt;
        end
      end
    end
  endfunction

  task automatic checkInst(input string name, input int i, input int c, input int r,
                           input int w, input int d);
    checkOutput({name, ".cnt"},   c, mCnt[i]);
    checkOutput({name, ".ready"}, r, mReady[i]);
    checkOutput({name, ".wrap"},  w, mWrap[i]);
    checkOutput({name, ".done"},  d, mDone[i]);
  endtask

  task automatic checkAll();
    checkInst("A", 0, int'(busA.cnt), int'(busA.ready), int'(busA.wrap), int'(busA.done));
    checkInst("B", 1, int'(busB.cnt), int'(busB.ready), int'(busB.wrap), int'(busB.done));
    checkInst("C", 2, int'(busC.cnt), int'(busC.ready), int'(busC.wrap), int'(busC.done));
    checkInst("D", 3, int'(busD.cnt), int'(busD.ready), int'(busD.wrap), int'(busD.done));
  endtask

  task automatic applyStimulus(input logic en, input logic cl, input logic ld,
                               input int lv, input logic dn);
    enable = en;
    clear  = cl;
    load   = ld;
    lvRaw  = 10'(lv);
`ifdef ADDR_SEQ_DOWN_EN
    down   = dn;
`else
    down   = 1'b0 & dn;
`endif
    @(posedge clk);
    #1;
    modelStep();
    checkAll();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0; down = 1'b0; lvRaw = '0;
    modelReset();
    #12;
    checkAll();
    rst = 1'b0;

    // Warm-up, wrap at 5, saturation at 5.
    repeat (14) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Priority clear > load > enable, then clamped loads.
    applyStimulus(1'b1, 1'b1, 1'b1, 7, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 600, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);

`ifdef ADDR_SEQ_DOWN_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
`endif

    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      applyStimulus($urandom_range(0, 3) != 0, r < 3, (r >= 3 && r < 9),
                    int'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset between edges while counting.
    applyStimulus(1'b0, 1'b0, 1'b1, 199, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    #2;
    rst = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule : tb_addr_seq_counter
